uart_ctl: RTL
=============

Name: uart_ctl

Overview:
- Register-mapped controller in front of the existing `uart` core.
- Buffers transmit and receive bytes in small FIFOs.
- Sequences the core's four-phase load/unload handshakes (ld_tx_req/ld_tx_ack and rx_req/rx_ack).
- Exposes status, control and an interrupt line to the host bus (CPU/Unibus-side I/O glue).

Parameters:
- FIFO_DEPTH, 4, entries per FIFO; power of two, minimum 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, FIFO occupancy counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- addr  in  2  register select: 0 = DATA, 1 = STATUS, 2 = CONTROL, 3 = reserved (reads 0)
- wr  in  1  write strobe, one cycle
- rd  in  1  read strobe, one cycle
- wdata  in  8  write data
- rdata  out  8  registered read data, valid the cycle after rd
- irq  out  1  level interrupt
- ld_tx_req  out  1  core TX load request
- ld_tx_ack  in  1  core TX load acknowledge
- tx_data  out  8  byte offered to core
- tx_empty  in  1  core transmitter idle
- tx_enable  out  1  CONTROL bit 2
- rx_req  out  1  core RX unload request
- rx_ack  in  1  core RX acknowledge
- rx_data  in  8  byte from core
- rx_empty  in  1  core holds no byte
- rx_enable  out  1  CONTROL bit 3

Behaviour:
- Reset values:
  - FIFOs empty; ld_tx_req = rx_req = 0; tx_data = 0; rdata = 0; irq = 0.
  - CONTROL = 0x0C (tx/rx enabled, interrupts off); sticky flags = 0.
  - Reset mid-handshake drops req the next edge, and the in-flight byte is discarded.
- DATA write: pushes wdata to the TX FIFO. If the FIFO is full, the byte is dropped and tx_ovf is set.
- DATA read: rdata gets the RX FIFO head and the entry is popped. If the FIFO is empty, rdata = 0 and nothing changes.
- STATUS (read-only):
  - b0 rx_avail
  - b1 tx_not_full
  - b2 rx_ovf
  - b3 tx_ovf
  - b4 tx_idle (TX FIFO empty, TX FSM idle, tx_empty = 1)
  - b5 rx_ie
  - b6 tx_ie
  - b7 = 0
- CONTROL: b0 rx_ie, b1 tx_ie, b2 tx_enable, b3 rx_enable.
  - Writing b7 = 1 clears rx_ovf/tx_ovf; b7 is not stored and reads back 0.
- TX FSM, with tx_data = FIFO head held stable throughout:
  - T_IDLE -> T_REQ when FIFO not empty, tx_empty = 1, ld_tx_ack = 0 and tx_enable. ld_tx_req = 1 from the next cycle.
  - T_REQ: hold ld_tx_req until ld_tx_ack = 1, then drop req, pop FIFO and go to T_ACKLO.
  - T_ACKLO -> T_IDLE when ld_tx_ack = 0.
  - A new load is never started until tx_empty returns 1, so the core never sees an overrun.
- RX FSM:
  - R_IDLE -> R_REQ when rx_empty = 0, RX FIFO not full and rx_enable; rx_req = 1.
  - R_REQ: on rx_ack = 1, capture rx_data into the FIFO, drop req, go to R_ACKLO.
  - R_ACKLO -> R_IDLE when rx_ack = 0.
  - RX FIFO full: the FSM stays idle and the byte remains in the core. The core's own overrun is not visible.
  - rx_ovf is set only if a push coincides with a full FIFO; this is not reachable by design and is kept as an assertion/flag.
- Simultaneous events:
  - Host DATA write and TX pop in the same cycle: both occur, occupancy unchanged; a full FIFO accepts the write.
  - Host DATA read and RX push in the same cycle: both occur.
  - wr and rd in the same cycle: both honoured.
- irq = (rx_ie & rx_avail) | (tx_ie & tx_not_full), registered (1 cycle latency).
- FIFO pointers wrap modulo FIFO_DEPTH; the occupancy counter is CNT_W bits wide.

Decomposition:
- Package uart_ctl_pkg holds:
  - register address constants (REG_DATA = 0, REG_STATUS = 1, REG_CONTROL = 2)
  - STATUS/CONTROL bit indices
  - TX/RX FSM state enums (2 bits each)
  - CONTROL reset value 0x0C
- Sub-module uart_ctl_fifo: synchronous 8-bit FIFO with push, pop, full, empty and count. Instantiated twice, for TX and RX.

Test Plan:
- Reset → irq = 0, ld_tx_req = 0, rx_req = 0; STATUS read = 0x12; CONTROL read = 0x0C.
- Write 0x41 then 0x42 to DATA, with a core model holding tx_empty = 0 for 100 cycles after each load → tx_data = 0x41 on the first handshake, 0x42 on the second. Second ld_tx_req rises only after tx_empty = 1 and ld_tx_ack = 0.
- With tx_enable = 0, five DATA writes → STATUS = 0x08 (b1 = 0, b3 = 1); four bytes later emitted in order. CONTROL write 0x8C → b3 clears.
- Core model presents rx_empty = 0 with rx_data = 0x5A → rx_req asserts, byte captured at rx_ack, STATUS b0 = 1. DATA read → rdata = 0x5A next cycle, b0 = 0.
- Fill the RX FIFO with 4 bytes, core holds a 5th byte (0x77) → rx_req stays 0. One DATA read → rx_req asserts within 2 cycles and 0x77 becomes the 4th entry.
- CONTROL = 0x0D (rx_ie) and one byte received → irq = 1; DATA read → irq = 0 two cycles later. Assert reset during R_REQ → rx_req = 0 the next cycle and the FIFO is empty.

Source files
------------

// File: rtl/uart_ctl_pkg.sv
// Shared constants for uart_ctl: register map, STATUS/CONTROL bit positions,
// handshake FSM state encodings and the CONTROL reset value.
package uart_ctl_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;

  localparam int ST_RX_AVAIL    = 0;
  localparam int ST_TX_NOT_FULL = 1;
  localparam int ST_RX_OVF      = 2;
  localparam int ST_TX_OVF      = 3;
  localparam int ST_TX_IDLE     = 4;
  localparam int ST_RX_IE       = 5;
  localparam int ST_TX_IE       = 6;

  localparam int CT_RX_IE   = 0;
  localparam int CT_TX_IE   = 1;
  localparam int CT_TX_EN   = 2;
  localparam int CT_RX_EN   = 3;
  localparam int CT_OVF_CLR = 7;

  localparam logic [7:0] CTRL_RST = 8'h0C;

  typedef enum logic [1:0] {T_IDLE, T_REQ, T_ACKLO} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_ACKLO} rx_state_e;

endpackage

// File: rtl/uart_ctl_fifo.sv
// Synchronous 8-bit FIFO; head visible combinationally on dout.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_ctl_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_ctl.sv
// Register-mapped front end for the uart core: host DATA/STATUS/CONTROL registers,
// TX/RX byte FIFOs and the four-phase load/unload handshakes toward the core.
module uart_ctl
  import uart_ctl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] addr,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  output logic       ld_tx_req,
  input  logic       ld_tx_ack,
  output logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       tx_enable,
  output logic       rx_req,
  input  logic       rx_ack,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       rx_enable
);

  tx_state_e  tx_state_q, tx_state_d;
  logic       ld_tx_req_q, ld_tx_req_d;
  logic [7:0] tx_data_q, tx_data_d;
  rx_state_e  rx_state_q, rx_state_d;
  logic       rx_req_q, rx_req_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic       rx_ovf_q, rx_ovf_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic [7:0] rdata_q, rdata_d;
  logic       irq_q, irq_d;

  logic             tx_push, tx_pop, tx_full, tx_fempty;
  logic             rx_push, rx_pop, rx_full, rx_fempty;
  logic [7:0]       tx_head, rx_head;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic             tx_idle;
  logic [7:0]       status;
  logic             unused_bits;

  assign tx_push = wr && (addr == REG_DATA);
  assign rx_pop  = rd && (addr == REG_DATA);

  uart_ctl_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   (wdata),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_fempty),
    .count (tx_cnt)
  );

  uart_ctl_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .din   (rx_data),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_fempty),
    .count (rx_cnt)
  );

  assign tx_idle = tx_fempty && (tx_state_q == T_IDLE) && tx_empty;

  always_comb begin
    status                 = 8'h00;
    status[ST_RX_AVAIL]    = !rx_fempty;
    status[ST_TX_NOT_FULL] = !tx_full;
    status[ST_RX_OVF]      = rx_ovf_q;
    status[ST_TX_OVF]      = tx_ovf_q;
    status[ST_TX_IDLE]     = tx_idle;
    status[ST_RX_IE]       = ctrl_q[CT_RX_IE];
    status[ST_TX_IE]       = ctrl_q[CT_TX_IE];
  end

  // TX: the byte is latched at request time so it stays stable until the pop.
  always_comb begin
    tx_state_d  = tx_state_q;
    ld_tx_req_d = ld_tx_req_q;
    tx_data_d   = tx_data_q;
    tx_pop      = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!tx_fempty && tx_empty && !ld_tx_ack && ctrl_q[CT_TX_EN]) begin
          tx_state_d  = T_REQ;
          ld_tx_req_d = 1'b1;
          tx_data_d   = tx_head;
        end
      end
      T_REQ: begin
        if (ld_tx_ack) begin
          tx_state_d  = T_ACKLO;
          ld_tx_req_d = 1'b0;
          tx_pop      = 1'b1;
        end
      end
      T_ACKLO: begin
        if (!ld_tx_ack) tx_state_d = T_IDLE;
      end
      default: begin
        tx_state_d  = T_IDLE;
        ld_tx_req_d = 1'b0;
      end
    endcase
  end

  // RX: only request while there is room, so a full FIFO leaves the byte in the core.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_req_d   = rx_req_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (!rx_empty && !rx_full && ctrl_q[CT_RX_EN]) begin
          rx_state_d = R_REQ;
          rx_req_d   = 1'b1;
        end
      end
      R_REQ: begin
        if (rx_ack) begin
          rx_state_d = R_ACKLO;
          rx_req_d   = 1'b0;
          rx_push    = 1'b1;
        end
      end
      R_ACKLO: begin
        if (!rx_ack) rx_state_d = R_IDLE;
      end
      default: begin
        rx_state_d = R_IDLE;
        rx_req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    rx_ovf_d = rx_ovf_q;
    tx_ovf_d = tx_ovf_q;
    rdata_d  = rdata_q;
    if (wr && (addr == REG_CONTROL)) begin
      ctrl_d = wdata[3:0];
      if (wdata[CT_OVF_CLR]) begin
        rx_ovf_d = 1'b0;
        tx_ovf_d = 1'b0;
      end
    end
    if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_push && rx_full && !rx_pop) rx_ovf_d = 1'b1;
    if (rd) begin
      case (addr)
        REG_DATA:    rdata_d = rx_fempty ? 8'h00 : rx_head;
        REG_STATUS:  rdata_d = status;
        REG_CONTROL: rdata_d = {4'h0, ctrl_q};
        default:     rdata_d = 8'h00;
      endcase
    end
    irq_d = (ctrl_q[CT_RX_IE] && !rx_fempty) || (ctrl_q[CT_TX_IE] && !tx_full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q  <= T_IDLE;
      ld_tx_req_q <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      tx_state_q  <= tx_state_d;
      ld_tx_req_q <= ld_tx_req_d;
      tx_data_q   <= tx_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= R_IDLE;
      rx_req_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_req_q   <= rx_req_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= CTRL_RST[3:0];
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      rdata_q  <= 8'h00;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign rdata     = rdata_q;
  assign irq       = irq_q;
  assign ld_tx_req = ld_tx_req_q;
  assign tx_data   = tx_data_q;
  assign rx_req    = rx_req_q;
  assign tx_enable = ctrl_q[CT_TX_EN];
  assign rx_enable = ctrl_q[CT_RX_EN];

  assign unused_bits = ^{tx_cnt, rx_cnt, wdata[6:4]};

endmodule
